// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for a shared
//               combinational ALU. Accepts one operation at a time, holds the
//               operands on the ALU for EXEC_CYCLES cycles, captures the
//               result and flags, and presents them on a valid/ready response
//               port until the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  // ALU settle time in cycles between operand launch and result capture.
  // Legal range is 1..4, which fits the 2-bit execution counter.
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_opcode,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_opcode,

  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_out,
  input  logic [4:0] alu_flags,

  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_out,
  output logic [4:0] rsp_flags,

  output logic       busy
);

  // Counter value reached in the final EXEC cycle.
  localparam logic [1:0] c_exec_last = 2'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic       r_last_grant;   // 1: requester 1 was granted last
  logic       w_grant_id;     // requester that would win this cycle
  logic       w_accept;       // an operation transfers on the next edge
  logic       w_exec_last;    // final cycle of EXEC, result captured on edge
  logic       w_rsp_fire;     // response consumed on the next edge

  logic [3:0] r_op_a;
  logic [3:0] r_op_b;
  logic [2:0] r_op_code;
  logic       r_req_id;
  logic [1:0] r_exec_cnt;

  logic       r_rsp_id;
  logic [7:0] r_rsp_out;
  logic [4:0] r_rsp_flags;

  // Round-robin pick: a lone valid wins; under contention the requester
  // that was not granted last wins.
  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end else begin
      w_grant_id = 1'b0;
    end
  end

  // Ready is offered only in IDLE and only to the granted, valid requester.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      req0_ready = req0_valid & ~w_grant_id;
      req1_ready = req1_valid &  w_grant_id;
    end
  end

  assign w_accept    = req0_ready | req1_ready;
  assign w_exec_last = (r_state == ST_EXEC) && (r_exec_cnt == c_exec_last);
  assign w_rsp_fire  = (r_state == ST_RESP) && rsp_ready;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: IDLE -> EXEC on transfer, EXEC -> RESP after the
  // settle window, RESP -> IDLE once the consumer takes the response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_exec_last) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_rsp_fire) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Grant history moves only when an operation actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant_id;
    end
  end

  // Operand registers feed the ALU directly and hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a    <= 4'h0;
      r_op_b    <= 4'h0;
      r_op_code <= 3'b000;
      r_req_id  <= 1'b0;
    end else if (w_accept) begin
      r_op_a    <= w_grant_id ? req1_a      : req0_a;
      r_op_b    <= w_grant_id ? req1_b      : req0_b;
      r_op_code <= w_grant_id ? req1_opcode : req0_opcode;
      r_req_id  <= w_grant_id;
    end
  end

  // Execution counter: cleared on transfer, counts EXEC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exec_cnt <= 2'd0;
    end else if (w_accept) begin
      r_exec_cnt <= 2'd0;
    end else if ((r_state == ST_EXEC) && !w_exec_last) begin
      r_exec_cnt <= r_exec_cnt + 2'd1;
    end
  end

  // Capture the settled ALU result at the end of the last EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_id    <= 1'b0;
      r_rsp_out   <= 8'h00;
      r_rsp_flags <= 5'b00000;
    end else if (w_exec_last) begin
      r_rsp_id    <= r_req_id;
      r_rsp_out   <= alu_out;
      r_rsp_flags <= alu_flags;
    end
  end

  assign alu_a      = r_op_a;
  assign alu_b      = r_op_b;
  assign alu_opcode = r_op_code;

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_out    = r_rsp_out;
  assign rsp_flags  = r_rsp_flags;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
